// File: rtl/mem_arb_pkg.sv
// Shared types and micro-code bit positions for the two-port memory access arbiter.
// Optional feature macro used by this block: MEM_ARB_RR_EN (round-robin arbitration).
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD   = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Bit positions inside the 32-bit memory control word
  localparam int MC_LD_MAR = 4;  // MAR <= mem_addr
  localparam int MC_RD_MEM = 3;  // MBR <= mem[MAR]
  localparam int MC_LD_MBR = 2;  // MBR <= mem_data_in
  localparam int MC_WR_MEM = 1;  // mem[MAR] <= MBR

  // One-hot control word with a single bit set
  function automatic logic [31:0] mc_bit(input int pos);
    return 32'(1) << pos;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester handshake and memory-side bus of the memory access arbiter.
// Vectors are indexed by requester port (0 or 1).
interface mem_access_arbiter_if;
  logic [1:0]       req;
  logic [1:0]       we;
  logic [1:0][7:0]  addr;
  logic [1:0][15:0] wdata;
  logic [1:0]       done;
  logic [15:0]      rdata;
  logic             busy;
  logic [31:0]      mem_micro_code;
  logic [7:0]       mem_addr;
  logic [15:0]      mem_data_in;
  logic [15:0]      mem_data_out;

  // Arbiter side
  modport slave (
    input  req, we, addr, wdata, mem_data_out,
    output done, rdata, busy, mem_micro_code, mem_addr, mem_data_in
  );

  // Requester / memory environment side
  modport master (
    output req, we, addr, wdata, mem_data_out,
    input  done, rdata, busy, mem_micro_code, mem_addr, mem_data_in
  );
endinterface

// File: rtl/mem_arb_picker.sv
// Grant decision between the two requesters. Purely combinational.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise port 0 always wins.
module mem_arb_picker (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       grant_valid,
  output logic       grant_port
);

  assign grant_valid = |req;

`ifdef MEM_ARB_RR_EN
  // On contention hand the grant to the port that was not served last
  always_comb begin
    grant_port = req[1];
    if (&req) begin
      grant_port = ~last_served;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it requests; history is not needed
  logic unused_last_served;
  assign unused_last_served = last_served;

  always_comb begin
    grant_port = ~req[0];
  end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-port arbiter sequencing single-word reads/writes through a MAR/MBR memory.
// Access flow: IDLE -> LD -> RD|WR -> DONE -> IDLE (done three cycles after sampling).
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed priority).
module mem_access_arbiter
  import mem_arb_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  mem_access_arbiter_if.slave  bus
);

  state_t        state_reg, state_next;
  logic          port_reg;
  logic          we_reg;
  logic [7:0]    addr_reg;
  logic [15:0]   wdata_reg;
  logic          last_served_reg;
  logic          grant_valid;
  logic          grant_port;
  logic [31:0]   mc_comb;
  logic [1:0]    done_comb;
  logic [15:0]   rdata_comb;

  mem_arb_picker u_picker (
    .req         (bus.req),
    .last_served (last_served_reg),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // State register plus operand capture at the moment a request leaves IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      port_reg        <= 1'b0;
      we_reg          <= 1'b0;
      addr_reg        <= 8'h00;
      wdata_reg       <= 16'h0000;
      last_served_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && grant_valid) begin
        port_reg  <= grant_port;
        we_reg    <= bus.we[grant_port];
        addr_reg  <= bus.addr[grant_port];
        wdata_reg <= bus.wdata[grant_port];
`ifdef MEM_ARB_RR_EN
        last_served_reg <= grant_port;
`endif
      end
    end
  end

  // Next-state logic and per-state memory control / completion outputs
  always_comb begin
    state_next = state_reg;
    mc_comb    = '0;
    done_comb  = '0;
    rdata_comb = '0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) state_next = ST_LD;
      end
      ST_LD: begin
        mc_comb = mc_bit(MC_LD_MAR);
        if (we_reg) begin
          mc_comb    = mc_comb | mc_bit(MC_LD_MBR);
          state_next = ST_WR;
        end else begin
          state_next = ST_RD;
        end
      end
      ST_RD: begin
        mc_comb    = mc_bit(MC_RD_MEM);
        state_next = ST_DONE;
      end
      ST_WR: begin
        mc_comb    = mc_bit(MC_WR_MEM);
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done_comb[port_reg] = 1'b1;
        if (!we_reg) rdata_comb = bus.mem_data_out;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Reset gates the control word immediately so an interrupted access never touches memory
  assign bus.mem_micro_code = rst ? 32'h0 : mc_comb;
  assign bus.mem_addr       = addr_reg;
  assign bus.mem_data_in    = wdata_reg;
  assign bus.done           = done_comb;
  assign bus.rdata          = rdata_comb;
  assign bus.busy           = (state_reg != ST_IDLE);

endmodule
